ocp_sram: RTL and testbench

OCP_SRAM -- requirements
Module: ocp_sram

---
 rtl/ocp_sram.sv | 132 +++++++++++++
 tb/tb_ocp_sram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ocp_sram.sv
// OCP slave SRAM with byte enables and a configurable number of command wait states.
// Define OCP_SRAM_ERR_RESP_EN to answer out-of-range or reserved commands with ERR.
module ocp_sram #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BEN_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [ADDR_WIDTH-1:0] i_MAddr,
  input  logic [2:0]            i_MCmd,
  input  logic [DATA_WIDTH-1:0] i_MData,
  input  logic [BEN_WIDTH-1:0]  i_MByteEn,
  output logic                  o_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_SData,
  output logic [1:0]            o_SResp
);

  localparam int unsigned IdxW  = $clog2(DEPTH);
  localparam int unsigned WordW = ADDR_WIDTH - 2;

  localparam logic [2:0] CmdIdle  = 3'd0;
  localparam logic [2:0] CmdWrite = 3'd1;
  localparam logic [2:0] CmdRead  = 3'd2;

  localparam logic [1:0] RespNull = 2'd0;
  localparam logic [1:0] RespDva  = 2'd1;
  localparam logic [1:0] RespErr  = 2'd3;

  typedef enum logic {StIdle, StWait} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  accept;
  logic [1:0]            resp_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [WordW-1:0] word_idx;
  logic [IdxW-1:0]  mem_idx;
  logic             is_write, is_read, err;
  logic             unused_bits;

  assign word_idx    = i_MAddr[ADDR_WIDTH-1:2];
  assign mem_idx     = word_idx[IdxW-1:0];
  assign unused_bits = ^{i_MAddr[1:0], word_idx};

`ifdef OCP_SRAM_ERR_RESP_EN
  logic oob, reserved;
  assign oob      = {1'b0, word_idx} >= (WordW + 1)'(DEPTH);
  assign reserved = (i_MCmd != CmdWrite) && (i_MCmd != CmdRead);
  assign err      = oob | reserved;
  assign is_write = (i_MCmd == CmdWrite) && !oob;
  assign is_read  = (i_MCmd == CmdRead) && !oob;
`else
  // Out-of-range indices simply wrap; reserved commands complete silently.
  assign err      = 1'b0;
  assign is_write = (i_MCmd == CmdWrite);
  assign is_read  = (i_MCmd == CmdRead);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_MCmd != CmdIdle) begin
          if (WAIT_STATES == 0) begin
            accept = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      StWait: begin
        if (i_MCmd == CmdIdle) begin
          // Master withdrew the command: drop it without any access.
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          accept  = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!nrst) accept = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      resp_q  <= RespNull;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && is_read) begin
        resp_q <= RespDva;
        data_q <= mem[mem_idx];
      end else if (accept && err) begin
        resp_q <= RespErr;
        data_q <= '0;
      end else begin
        resp_q <= RespNull;
        data_q <= '0;
      end
    end
  end

  // Memory has no reset so its contents survive nrst.
  always_ff @(posedge clk) begin
    if (accept && is_write) begin
      for (int k = 0; k < int'(BEN_WIDTH); k++) begin
        if (i_MByteEn[k]) mem[mem_idx][8*k +: 8] <= i_MData[8*k +: 8];
      end
    end
  end

  assign o_SCmdAccept = accept;
  assign o_SResp      = resp_q;
  assign o_SData      = data_q;

endmodule

// File: tb/tb_ocp_sram.sv
// Randomized bench for ocp_sram: one instance with no wait states, one with three,
// both checked every cycle against a word-array reference model.
module tb_ocp_sram;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WS0   = 0;
  localparam int unsigned WS1   = 3;

  localparam logic [2:0] CMD_IDLE  = 3'd0;
  localparam logic [2:0] CMD_WRITE = 3'd1;
  localparam logic [2:0] CMD_READ  = 3'd2;
  localparam logic [1:0] R_NULL    = 2'd0;
  localparam logic [1:0] R_DVA     = 2'd1;
  localparam logic [1:0] R_ERR     = 2'd3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       nrst;
  logic [1:0][31:0] maddr;
  logic [1:0][2:0]  mcmd;
  logic [1:0][31:0] mdata;
  logic [1:0][3:0]  mben;
  logic [1:0]       accept;
  logic [1:0][31:0] sdata;
  logic [1:0][1:0]  sresp;

  ocp_sram #(.DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
    .clk(clk), .nrst(nrst[0]), .i_MAddr(maddr[0]), .i_MCmd(mcmd[0]), .i_MData(mdata[0]),
    .i_MByteEn(mben[0]), .o_SCmdAccept(accept[0]), .o_SData(sdata[0]), .o_SResp(sresp[0])
  );

  ocp_sram #(.DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
    .clk(clk), .nrst(nrst[1]), .i_MAddr(maddr[1]), .i_MCmd(mcmd[1]), .i_MData(mdata[1]),
    .i_MByteEn(mben[1]), .o_SCmdAccept(accept[1]), .o_SData(sdata[1]), .o_SResp(sresp[1])
  );

  // Reference model: words 0..15 of each instance, plus the response due next cycle.
  logic [31:0]      mdl [2][16];
  logic [1:0][1:0]  pend_resp;
  logic [1:0][31:0] pend_data;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Call at a negedge: compares the response for this cycle, then clears the expectation.
  task automatic check_resp(input int d);
    check_eq($sformatf("resp%0d", d), 32'(sresp[d]), 32'(pend_resp[d]));
    check_eq($sformatf("sdata%0d", d), sdata[d], pend_data[d]);
    pend_resp[d] = R_NULL;
    pend_data[d] = '0;
  endtask

  task automatic model_apply(input int d, input logic [2:0] cmd, input logic [31:0] addr,
                             input logic [31:0] data, input logic [3:0] be);
    int unsigned widx;
    int unsigned idx;
    logic        reserved;
    widx     = addr >> 2;
    idx      = widx % DEPTH;
    reserved = (cmd != CMD_WRITE) && (cmd != CMD_READ);
`ifdef OCP_SRAM_ERR_RESP_EN
    if (reserved || widx >= DEPTH) begin
      pend_resp[d] = R_ERR;
      pend_data[d] = '0;
      return;
    end
`else
    if (reserved) begin
      pend_resp[d] = R_NULL;
      pend_data[d] = '0;
      return;
    end
`endif
    if (cmd == CMD_WRITE) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mdl[d][idx[3:0]][8*k +: 8] = data[8*k +: 8];
      end
      pend_resp[d] = R_NULL;
      pend_data[d] = '0;
    end else begin
      pend_resp[d] = R_DVA;
      pend_data[d] = mdl[d][idx[3:0]];
    end
  endtask

  // Entered and left just after a posedge; holds the command until accepted.
  task automatic issue(input int d, input logic [2:0] cmd, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    int   waited = 0;
    logic got    = 1'b0;
    mcmd[d]  = cmd;
    maddr[d] = addr;
    mdata[d] = data;
    mben[d]  = be;
    while (!got && waited <= 40) begin
      @(negedge clk);
      check_resp(d);
      if (accept[d]) got = 1'b1;
      else begin
        waited++;
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      mcmd[d] = CMD_IDLE;
      @(posedge clk);
      #1;
      return;
    end
    check_eq($sformatf("latency%0d", d), 32'(waited), (d == 0) ? WS0 : WS1);
    model_apply(d, cmd, addr, data, be);
    @(posedge clk);
    #1;
    mcmd[d] = CMD_IDLE;
  endtask

  task automatic idle(input int d);
    mcmd[d] = CMD_IDLE;
    @(negedge clk);
    check_resp(d);
    check_eq($sformatf("idle_accept%0d", d), 32'(accept[d]), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic random_ops(input int d, input int n);
    logic [2:0]  cmd;
    logic [31:0] addr;
    int unsigned sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 9) cmd = CMD_WRITE;
      else if (sel < 18) cmd = CMD_READ;
      else cmd = 3'($urandom_range(3, 7));
      addr = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) addr = addr + (32'($urandom_range(1, 3)) << 12);
      addr = addr | 32'($urandom_range(0, 3));
      issue(d, cmd, addr, $urandom, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 3) == 0) idle(d);
    end
    idle(d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nrst      = '0;
    maddr     = '0;
    mdata     = '0;
    mben      = '0;
    mcmd      = '0;
    mcmd[0]   = CMD_READ;  // accept must stay low while in reset
    pend_resp = '0;
    pend_data = '0;
    @(negedge clk);
    check_eq("rst_accept0", 32'(accept[0]), 32'd0);
    check_eq("rst_accept1", 32'(accept[1]), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_eq("rst_accept0b", 32'(accept[0]), 32'd0);
    check_resp(0);
    check_resp(1);
    @(posedge clk);
    #1;
    mcmd[0] = CMD_IDLE;
    nrst    = '1;
    idle(0);

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) issue(d, CMD_WRITE, 32'(w) << 2, $urandom, 4'hf);
      idle(d);
    end

    // Full write then read, then a partial write over it.
    issue(0, CMD_WRITE, 32'h0, 32'hdeadbeef, 4'hf);
    issue(0, CMD_READ, 32'h0, 32'h0, 4'h0);
    idle(0);
    issue(0, CMD_WRITE, 32'h0, 32'hbeefdead, 4'h3);
    issue(0, CMD_READ, 32'h0, 32'h0, 4'h0);
    idle(0);
    // Back-to-back write/read of the same word, no gap.
    issue(0, CMD_WRITE, 32'h8, 32'h12345678, 4'hf);
    issue(0, CMD_READ, 32'h8, 32'h0, 4'h0);
    // Index beyond DEPTH: ERR or wrap to word 0.
    issue(0, CMD_READ, 32'h1000, 32'h0, 4'h0);
    idle(0);

    // Wait-state latency on a held read.
    issue(1, CMD_READ, 32'h4, 32'h0, 4'h0);
    idle(1);

    // Reset in the cycle the write would have been accepted.
    mcmd[1]  = CMD_WRITE;
    maddr[1] = 32'hc;
    mdata[1] = ~mdl[1][3];
    mben[1]  = 4'hf;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_resp(1);
      check_eq("wait_accept", 32'(accept[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    nrst[1] = 1'b0;
    @(negedge clk);
    check_eq("rst_wait_accept", 32'(accept[1]), 32'd0);
    @(posedge clk);
    #1;
    nrst[1] = 1'b1;
    idle(1);
    issue(1, CMD_READ, 32'hc, 32'h0, 4'h0);
    idle(1);

    random_ops(0, 150);
    random_ops(1, 150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
